backprop_layer_stack: RTL and testbench
=======================================

// Module: backprop_layer_stack
// PURPOSE
//  LIFO layer store for backprop. The forward pass writes per-layer row vectors for NUM_SETS data sets
//  (set 0 = pre-activation/start, set 1 = activation, ...) into an open frame, then commits the frame with push.
//  The backward pass reads committed frames by depth from the top (0 = most recent layer), then releases them with pop.
//  Generalises the single-layer start/act store: multi-layer depth, N data sets, bounds checking and status flags.
// PARAMETERS
//  DATA_SIZE       16  bits per element (fixed point, 8 fractional bits)
//  SIZE            3   elements per row vector
//  MAX_LAYER_SIZE  5   rows per layer frame
//  MAX_LAYERS      4   frame capacity of the stack
//  NUM_SETS        2   data sets per row
// PORTS
//  clk           in   1               rising-edge clock
//  reset         in   1               synchronous, active-high
//  store         in   1               write store_data to open frame [store_set][store_row]
//  store_set     in   32              data-set index
//  store_row     in   32              row index
//  store_data    in   DATA_SIZE*SIZE  row vector, element 0 in MSBs
//  push          in   1               commit open frame; open next frame
//  pop           in   1               discard top committed frame
//  load          in   1               read request
//  load_depth    in   32              0 = top committed frame
//  load_set      in   32              data-set index
//  load_row      in   32              row index
//  load_data     out  DATA_SIZE*SIZE  read data, registered
//  load_valid    out  1               1-cycle pulse with load_data
//  load_error    out  1               1-cycle pulse: read request was out of range
//  store_error   out  1               1-cycle pulse: write request was out of range, or the stack was full
//  layer_count   out  32              number of committed frames (sp)
//  full / empty  out  1               sp==MAX_LAYERS / sp==0 (combinational from sp)
//  overflow      out  1               sticky: push attempted when full, or pop attempted when empty
// BEHAVIOUR
//  Storage: MAX_LAYERS*NUM_SETS*MAX_LAYER_SIZE words of DATA_SIZE*SIZE bits. Frame index f = sp on write, sp-1-load_depth on read.
//  Reset: sp=0; load_data=0; load_valid, load_error, store_error, overflow all =0. Memory contents are not cleared (don't-care).
//  Write: on a store edge, the word is written if store_set<NUM_SETS, store_row<MAX_LAYER_SIZE and sp<MAX_LAYERS.
//   - Otherwise the write is dropped and store_error pulses the next cycle.
//   - Rows not written in a frame hold stale data; no zero fill.
//  Push: sp<=sp+1 if sp<MAX_LAYERS; else sp is unchanged and overflow<=1.
//  Pop: sp<=sp-1 if sp>0; else sp is unchanged and overflow<=1.
//  push and pop in the same cycle: sp unchanged, no error, no frame content altered.
//  Read: latency 1. If load_depth<sp, load_set<NUM_SETS and load_row<MAX_LAYER_SIZE:
//   - load_data <= mem word, load_valid=1.
//  Otherwise load_data<=0, load_error=1, load_valid=0.
//  load_data holds its value until the next load or reset.
//  Simultaneous events, evaluated against the pre-edge sp:
//   - store+push: the write lands in the frame being committed.
//   - load+pop: the read uses the pre-pop frame mapping.
//   - load+push: the read ignores the newly committed frame.
//   - store to frame f and load of the same frame/set/row in one cycle: load returns the OLD word (read-before-write).
//  Reset asserted mid-operation: all state above returns to reset values at that edge. In-flight load is cancelled (no valid pulse).
//  overflow clears only on reset.
//  Arithmetic: data is stored and returned bit-exact; no scaling. Index ports are treated as unsigned 32-bit.
// TESTING
//  T1 Reset, then store set0 row0 = {1,2,3}<<8, set1 row0 = {4,5,6}<<8, then push.
//     Then load depth0 set1 row0 -> next cycle load_valid=1, load_data={0x0400,0x0500,0x0600}; layer_count=1.
//  T2 Four frames, row2 set0 = {k,k,k}<<8 for k=1..4, each pushed; full=1.
//     load depth0 -> k=4; depth3 -> k=1. A fifth push -> sp stays 4, overflow=1.
//  T3 From T2, pop twice -> layer_count=2; load depth0 row2 set0 -> k=2; load depth2 -> load_error=1, load_data=0.
//  T4 store_row=5 or store_set=2 -> store_error pulse; a later load of that slot shows no change.
//     pop on empty -> overflow=1.
//  T5 store+push in one cycle with row1 = {7,7,7}<<8 -> load depth0 row1 returns it.
//     push+pop together -> layer_count unchanged.
//  T6 Assert reset during a load cycle with sp=3 -> no load_valid; sp=0, empty=1, overflow=0.
//     A subsequent load depth0 -> load_error=1.

Source files
------------

// File: rtl/backprop_layer_stack.sv
// backprop_layer_stack
//   LIFO store of per-layer frames for backpropagation. The forward pass
//   writes row vectors (one per data set and row) into the open frame, which
//   sits at index sp. A push commits it. The backward pass reads committed
//   frames by depth from the top and releases them with a pop.
//
// Ports
//   clk, reset     rising-edge clock, synchronous active-high reset
//   store*         write store_data into open frame [store_set][store_row]
//   push / pop     commit open frame / discard top committed frame
//   load*          read committed frame (depth 0 = top), latency 1
//   load_data      registered read data; holds until the next load or reset
//   load_valid     1-cycle pulse alongside good load_data
//   load_error     1-cycle pulse for an out-of-range read (load_data = 0)
//   store_error    1-cycle pulse for a dropped write (bad index or full stack)
//   layer_count    committed frame count (sp)
//   full / empty   sp == MAX_LAYERS / sp == 0
//   overflow       sticky: push when full or pop when empty
module backprop_layer_stack #(
  parameter int unsigned DATA_SIZE      = 16,
  parameter int unsigned SIZE           = 3,
  parameter int unsigned MAX_LAYER_SIZE = 5,
  parameter int unsigned MAX_LAYERS     = 4,
  parameter int unsigned NUM_SETS       = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      store,
  input  logic [31:0]               store_set,
  input  logic [31:0]               store_row,
  input  logic [DATA_SIZE*SIZE-1:0] store_data,
  input  logic                      push,
  input  logic                      pop,
  input  logic                      load,
  input  logic [31:0]               load_depth,
  input  logic [31:0]               load_set,
  input  logic [31:0]               load_row,
  output logic [DATA_SIZE*SIZE-1:0] load_data,
  output logic                      load_valid,
  output logic                      load_error,
  output logic                      store_error,
  output logic [31:0]               layer_count,
  output logic                      full,
  output logic                      empty,
  output logic                      overflow
);

  localparam int unsigned DW    = DATA_SIZE * SIZE;
  localparam int unsigned DEPTH = MAX_LAYERS * NUM_SETS * MAX_LAYER_SIZE;
  localparam int unsigned AW    = $clog2(DEPTH);

  logic [DW-1:0] r_mem [DEPTH];
  logic [31:0]   r_sp;
  logic [DW-1:0] r_load_data;
  logic          r_load_valid;
  logic          r_load_error;
  logic          r_store_error;
  logic          r_overflow;

  logic          w_wr_ok;
  logic          w_rd_ok;
  logic [31:0]   w_rd_frame;
  logic [AW-1:0] w_wr_addr;
  logic [AW-1:0] w_rd_addr;

  // All decisions use the pre-edge sp, so a simultaneous store+push writes
  // the frame being committed and a load alongside push/pop sees the old
  // frame mapping.
  assign w_wr_ok = (store_set < NUM_SETS) && (store_row < MAX_LAYER_SIZE) &&
                   (r_sp < MAX_LAYERS);
  assign w_rd_ok = (load_depth < r_sp) && (load_set < NUM_SETS) &&
                   (load_row < MAX_LAYER_SIZE);

  assign w_rd_frame = r_sp - 32'd1 - load_depth;

  // Flat address (frame, set, row). Only meaningful when the matching *_ok
  // is set; otherwise the truncated value is never used.
  assign w_wr_addr = AW'((r_sp * NUM_SETS + store_set) * MAX_LAYER_SIZE + store_row);
  assign w_rd_addr = AW'((w_rd_frame * NUM_SETS + load_set) * MAX_LAYER_SIZE + load_row);

  // Storage is not reset. Nonblocking write gives read-before-write on a
  // same-cycle store and load of one word.
  always_ff @(posedge clk) begin
    if (!reset && store && w_wr_ok) begin
      r_mem[w_wr_addr] <= store_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sp       <= '0;
      r_overflow <= 1'b0;
    end else if (push && !pop) begin
      if (r_sp < MAX_LAYERS) r_sp <= r_sp + 32'd1;
      else                   r_overflow <= 1'b1;
    end else if (pop && !push) begin
      if (r_sp != 32'd0) r_sp <= r_sp - 32'd1;
      else               r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_load_data   <= '0;
      r_load_valid  <= 1'b0;
      r_load_error  <= 1'b0;
      r_store_error <= 1'b0;
    end else begin
      r_load_valid  <= 1'b0;
      r_load_error  <= 1'b0;
      r_store_error <= store && !w_wr_ok;
      if (load) begin
        if (w_rd_ok) begin
          r_load_data  <= r_mem[w_rd_addr];
          r_load_valid <= 1'b1;
        end else begin
          r_load_data  <= '0;
          r_load_error <= 1'b1;
        end
      end
    end
  end

  assign load_data   = r_load_data;
  assign load_valid  = r_load_valid;
  assign load_error  = r_load_error;
  assign store_error = r_store_error;
  assign layer_count = r_sp;
  assign full        = (r_sp == MAX_LAYERS);
  assign empty       = (r_sp == 32'd0);
  assign overflow    = r_overflow;

endmodule

// File: tb/tb_backprop_layer_stack.sv
module tb_backprop_layer_stack;

  logic        clk = 1'b0;
  logic        reset;
  logic        store;
  logic [31:0] store_set, store_row;
  logic [47:0] store_data;
  logic        push, pop, load;
  logic [31:0] load_depth, load_set, load_row;
  logic [47:0] load_data;
  logic        load_valid, load_error, store_error;
  logic [31:0] layer_count;
  logic        full, empty, overflow;

  backprop_layer_stack dut (
    .clk(clk), .reset(reset), .store(store), .store_set(store_set),
    .store_row(store_row), .store_data(store_data), .push(push), .pop(pop),
    .load(load), .load_depth(load_depth), .load_set(load_set),
    .load_row(load_row), .load_data(load_data), .load_valid(load_valid),
    .load_error(load_error), .store_error(store_error),
    .layer_count(layer_count), .full(full), .empty(empty), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        v;
    logic        e;
    logic [47:0] d;
  } exp_t;

  exp_t        sb[$];
  logic [47:0] mm [4][2][5];
  int unsigned msp;
  logic        movf;
  logic        exp_serr;
  int          ncmp = 0;
  int          nerr = 0;
  exp_t        x;

  function automatic logic [47:0] rep(input int k);
    logic [15:0] w;
    w = 16'(k << 8);
    return {w, w, w};
  endfunction

  task automatic idle_inputs();
    store = 0; store_set = 0; store_row = 0; store_data = 0;
    push = 0; pop = 0; load = 0; load_depth = 0; load_set = 0; load_row = 0;
  endtask

  // One clock of stimulus. Expectations come from the reference model using
  // pre-edge state; load results go to the scoreboard.
  task automatic step(input bit st, input int unsigned ss, input int unsigned sr,
                      input logic [47:0] sd, input bit pu, input bit po,
                      input bit ld, input int unsigned dep, input int unsigned ls,
                      input int unsigned lr);
    exp_t e;
    if (ld) begin
      if (dep < msp && ls < 2 && lr < 5) e = '{1'b1, 1'b0, mm[msp-1-dep][ls][lr]};
      else                               e = '{1'b0, 1'b1, 48'h0};
      sb.push_back(e);
    end
    exp_serr = st && !(ss < 2 && sr < 5 && msp < 4);
    if (st && !exp_serr) mm[msp][ss][sr] = sd;
    if (pu && !po) begin
      if (msp < 4) msp++; else movf = 1'b1;
    end else if (po && !pu) begin
      if (msp > 0) msp--; else movf = 1'b1;
    end
    store = st; store_set = ss; store_row = sr; store_data = sd;
    push = pu; pop = po; load = ld; load_depth = dep; load_set = ls; load_row = lr;
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    msp = 0; movf = 1'b0; exp_serr = 1'b0;
    sb.delete();
  endtask

  task automatic test_reset();
    do_reset();
    ncmp++;
    if ({load_data, load_valid, load_error, store_error} !== 51'h0) begin
      nerr++;
      $display("FAIL reset_outputs: got d=%h v=%0b le=%0b se=%0b, want all 0",
               load_data, load_valid, load_error, store_error);
    end
    ncmp++;
    if (layer_count !== 0 || empty !== 1'b1 || full !== 1'b0 || overflow !== 1'b0) begin
      nerr++;
      $display("FAIL reset_status: got sp=%0d e=%0b f=%0b ovf=%0b, want 0 1 0 0",
               layer_count, empty, full, overflow);
    end
  endtask

  task automatic test_single_frame();
    step(1, 0, 0, 48'h0100_0200_0300, 0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 48'h0400_0500_0600, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
    x = sb.pop_front();
    ncmp++;
    if ({load_valid, load_error, load_data} !== {x.v, x.e, x.d}) begin
      nerr++;
      $display("FAIL t1_load: got v=%0b e=%0b d=%h, want v=%0b e=%0b d=%h",
               load_valid, load_error, load_data, x.v, x.e, x.d);
    end
    ncmp++;
    if (layer_count !== msp) begin
      nerr++;
      $display("FAIL t1_count: got %0d, want %0d", layer_count, msp);
    end
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    ncmp++;
    if (load_valid !== 1'b0 || load_data !== x.d) begin
      nerr++;
      $display("FAIL t1_hold: got v=%0b d=%h, want v=0 d=%h", load_valid, load_data, x.d);
    end
  endtask

  task automatic test_full_stack();
    do_reset();
    for (int k = 1; k <= 4; k++) begin
      step(1, 0, 2, rep(k), 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    end
    ncmp++;
    if (full !== 1'b1 || layer_count !== msp || empty !== 1'b0) begin
      nerr++;
      $display("FAIL t2_full: got f=%0b sp=%0d e=%0b, want f=1 sp=%0d e=0",
               full, layer_count, empty, msp);
    end
    // back-to-back loads of every depth
    for (int d = 0; d < 4; d++) begin
      step(0, 0, 0, 0, 0, 0, 1, d, 0, 2);
      x = sb.pop_front();
      ncmp++;
      if ({load_valid, load_error, load_data} !== {x.v, x.e, x.d}) begin
        nerr++;
        $display("FAIL t2_load_depth%0d: got v=%0b e=%0b d=%h, want v=%0b e=%0b d=%h",
                 d, load_valid, load_error, load_data, x.v, x.e, x.d);
      end
    end
    step(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    ncmp++;
    if (layer_count !== 4 || overflow !== 1'b1 || movf !== 1'b1) begin
      nerr++;
      $display("FAIL t2_overpush: got sp=%0d ovf=%0b, want sp=4 ovf=1", layer_count, overflow);
    end
    step(1, 0, 0, rep(9), 0, 0, 0, 0, 0, 0);
    ncmp++;
    if (store_error !== exp_serr) begin
      nerr++;
      $display("FAIL t2_store_full: got store_error=%0b, want %0b", store_error, exp_serr);
    end
  endtask

  task automatic test_pop();
    step(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    ncmp++;
    if (layer_count !== msp || msp != 2) begin
      nerr++;
      $display("FAIL t3_count: got %0d, want 2", layer_count);
    end
    for (int d = 0; d < 3; d++) begin
      step(0, 0, 0, 0, 0, 0, 1, 2 - d, 0, 2);
      x = sb.pop_front();
      ncmp++;
      if ({load_valid, load_error, load_data} !== {x.v, x.e, x.d}) begin
        nerr++;
        $display("FAIL t3_load_depth%0d: got v=%0b e=%0b d=%h, want v=%0b e=%0b d=%h",
                 2 - d, load_valid, load_error, load_data, x.v, x.e, x.d);
      end
    end
  endtask

  task automatic test_errors();
    // A bad row/set would alias neighbouring slots if not dropped.
    step(1, 1, 0, rep(11), 0, 0, 0, 0, 0, 0);
    step(1, 0, 5, rep(12), 0, 0, 0, 0, 0, 0);
    ncmp++;
    if (store_error !== 1'b1) begin
      nerr++;
      $display("FAIL t4_bad_row: got store_error=%0b, want 1", store_error);
    end
    step(1, 2, 0, rep(13), 0, 0, 0, 0, 0, 0);
    ncmp++;
    if (store_error !== 1'b1) begin
      nerr++;
      $display("FAIL t4_bad_set: got store_error=%0b, want 1", store_error);
    end
    step(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    ncmp++;
    if (store_error !== 1'b0) begin
      nerr++;
      $display("FAIL t4_err_pulse: got store_error=%0b, want 0", store_error);
    end
    step(0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
    x = sb.pop_front();
    ncmp++;
    if ({load_valid, load_error, load_data} !== {x.v, x.e, x.d}) begin
      nerr++;
      $display("FAIL t4_no_alias: got v=%0b e=%0b d=%h, want v=%0b e=%0b d=%h",
               load_valid, load_error, load_data, x.v, x.e, x.d);
    end
    step(0, 0, 0, 0, 0, 0, 1, 0, 0, 1);
    x = sb.pop_front();
    ncmp++;
    if ({load_valid, load_error, load_data} !== {x.v, x.e, x.d}) begin
      nerr++;
      $display("FAIL t4_no_alias_next: got v=%0b e=%0b d=%h, want v=%0b e=%0b d=%h",
               load_valid, load_error, load_data, x.v, x.e, x.d);
    end
    do_reset();
    step(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    ncmp++;
    if (overflow !== movf || layer_count !== 0 || movf !== 1'b1) begin
      nerr++;
      $display("FAIL t4_pop_empty: got ovf=%0b sp=%0d, want ovf=1 sp=0", overflow, layer_count);
    end
  endtask

  task automatic test_simultaneous();
    step(1, 0, 1, rep(7), 1, 0, 0, 0, 0, 0);
    step(1, 0, 1, rep(8), 1, 0, 1, 0, 0, 1);   // load+push: ignores new frame
    step(0, 0, 0, 0, 1, 1, 1, 0, 0, 1);        // push+pop: no change
    step(0, 0, 0, 0, 0, 1, 1, 1, 0, 1);        // load+pop: pre-pop mapping
    step(0, 0, 0, 0, 0, 0, 1, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      x = sb.pop_front();
      ncmp++;
      if (i == 3 && {load_valid, load_error, load_data} !== {x.v, x.e, x.d}) begin
        nerr++;
        $display("FAIL t5_last_load: got v=%0b e=%0b d=%h, want v=%0b e=%0b d=%h",
                 load_valid, load_error, load_data, x.v, x.e, x.d);
      end
    end
    ncmp++;
    if (layer_count !== msp || overflow !== movf) begin
      nerr++;
      $display("FAIL t5_status: got sp=%0d ovf=%0b, want sp=%0d ovf=%0b",
               layer_count, overflow, msp, movf);
    end
  endtask

  // Each simultaneous case checked on its own cycle.
  task automatic test_back_to_back();
    do_reset();
    step(1, 0, 1, rep(7), 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0, 0, 1);
    x = sb.pop_front();
    ncmp++;
    if ({load_valid, load_error, load_data} !== {x.v, x.e, x.d}) begin
      nerr++;
      $display("FAIL t5_store_push: got v=%0b e=%0b d=%h, want v=%0b e=%0b d=%h",
               load_valid, load_error, load_data, x.v, x.e, x.d);
    end
    step(1, 1, 3, rep(5), 1, 0, 1, 1, 0, 1);
    x = sb.pop_front();
    ncmp++;
    if ({load_valid, load_error, load_data} !== {x.v, x.e, x.d}) begin
      nerr++;
      $display("FAIL t5_load_push: got v=%0b e=%0b d=%h, want v=%0b e=%0b d=%h",
               load_valid, load_error, load_data, x.v, x.e, x.d);
    end
    step(0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    ncmp++;
    if (layer_count !== msp || msp != 2 || overflow !== 1'b0) begin
      nerr++;
      $display("FAIL t5_push_pop: got sp=%0d ovf=%0b, want sp=2 ovf=0", layer_count, overflow);
    end
    step(0, 0, 0, 0, 0, 1, 1, 1, 0, 1);
    x = sb.pop_front();
    ncmp++;
    if ({load_valid, load_error, load_data} !== {x.v, x.e, x.d}) begin
      nerr++;
      $display("FAIL t5_load_pop: got v=%0b e=%0b d=%h, want v=%0b e=%0b d=%h",
               load_valid, load_error, load_data, x.v, x.e, x.d);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    step(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    for (int k = 1; k <= 3; k++) begin
      step(1, 1, 4, rep(k + 20), 1, 0, 0, 0, 0, 0);
    end
    ncmp++;
    if (overflow !== 1'b1 || layer_count !== 3) begin
      nerr++;
      $display("FAIL t6_setup: got ovf=%0b sp=%0d, want ovf=1 sp=3", overflow, layer_count);
    end
    load = 1; load_depth = 0; load_set = 1; load_row = 4; reset = 1;
    @(negedge clk);
    idle_inputs(); reset = 0;
    msp = 0; movf = 1'b0;
    ncmp++;
    if (load_valid !== 1'b0 || layer_count !== 0 || empty !== 1'b1 ||
        overflow !== 1'b0 || load_data !== 48'h0) begin
      nerr++;
      $display("FAIL t6_mid_reset: got v=%0b sp=%0d e=%0b ovf=%0b d=%h, want 0 0 1 0 0",
               load_valid, layer_count, empty, overflow, load_data);
    end
    step(0, 0, 0, 0, 0, 0, 1, 0, 1, 4);
    x = sb.pop_front();
    ncmp++;
    if ({load_valid, load_error, load_data} !== {x.v, x.e, x.d}) begin
      nerr++;
      $display("FAIL t6_load_after: got v=%0b e=%0b d=%h, want v=%0b e=%0b d=%h",
               load_valid, load_error, load_data, x.v, x.e, x.d);
    end
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    msp = 0; movf = 1'b0; exp_serr = 1'b0;
    @(negedge clk);
    test_reset();
    test_single_frame();
    test_full_stack();
    test_pop();
    test_errors();
    test_simultaneous();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, want finish before time limit");
    $fatal(1);
  end

endmodule
